spm_loader: RTL and testbench
=============================

# spm_loader

Boot-time program loader that sits upstream of the CPU top level and drives its test SPM port (`test_spm_*`) and `cpu_en`. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive SPM word addresses. The loader then reads the whole image back and checks a 32-bit sum, and releases the CPU by raising `cpu_en` only on a match.

## Interface
Parameters:
- `BASE_ADDR`, 30'h0: SPM word address of the first image word.
- `MAX_WORDS`, 4096: largest accepted image size in words.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts the byte this cycle (transfer when `rx_valid && rx_ready`).
- `spm_addr`  out  30  SPM word address, connected to `test_spm_addr`.
- `spm_as_`  out  1  active-low access strobe, connected to `test_spm_as_`.
- `spm_rw`  out  1  access direction, using the `READ`/`WRITE` encodings from define.v; connected to `test_spm_rw`.
- `spm_wr_data`  out  32  write data, connected to `test_spm_wr_data`.
- `spm_rd_data`  in  32  read data from `test_spm_rd_data`.
- `cpu_en`  out  1  CPU run enable; the CPU owns the SPM port while this is high.
- `busy`  out  1  a load or verify is in progress.
- `error`  out  1  the load failed.
- `err_code`  out  2  failure reason: 0 = none, 1 = size exceeds `MAX_WORDS`, 2 = checksum mismatch.

## Operation
- States: IDLE, HDR, DATA, WRITE, VREQ, VCHK, RUN, ERR.
- IDLE/RUN/ERR + `start`: go to HDR. On that same edge, clear `cpu_en`, `error`, `err_code`, the byte counter, the word index, `sum` and `vsum`.
- `start` in any other state is ignored.
- HDR (`rx_ready`=1):
  - Collect 4 bytes, LSB first, into word count N.
  - On the 4th byte: if N == 0, go to RUN. If N > `MAX_WORDS`, go to ERR with `err_code`=1. Otherwise go to DATA.
- DATA (`rx_ready`=1):
  - Each accepted byte shifts into a word register; byte k lands in bits [8k+7:8k].
  - On the 4th byte, go to WRITE.
- WRITE (`rx_ready`=0), one cycle:
  - Drive `spm_as_`=0, `spm_rw`=`WRITE`, `spm_addr`=`BASE_ADDR`+idx and `spm_wr_data`=word.
  - Update `sum` += word (mod 2^32) and idx += 1.
  - If idx+1 == N, clear idx and go to VREQ; otherwise go to DATA.
- VREQ, one cycle: drive `spm_as_`=0, `spm_rw`=`READ`, `spm_addr`=`BASE_ADDR`+idx, then go to VCHK.
- VCHK, one cycle:
  - SPM read data is valid in the cycle after the request; use `spm_rd_data` directly.
  - Update `vsum` += `spm_rd_data` and idx += 1.
  - Last word (idx+1 == N): if `vsum`+`spm_rd_data` == `sum`, go to RUN; otherwise go to ERR with `err_code`=2.
  - Not the last word: go to VREQ.
- RUN: `cpu_en`=1 and `spm_as_`=1; hold until `start` or reset.
- ERR: `error`=1, `cpu_en`=0, `rx_ready`=0; hold until `start` or reset.
- `busy`=1 in HDR, DATA, WRITE, VREQ and VCHK.
- In every state other than WRITE and VREQ: `spm_as_`=1, `spm_rw`=`READ`, `spm_wr_data`=0.
- Address arithmetic is 30-bit and wraps modulo 2^30.
- Bytes arriving beyond 4N are not accepted (`rx_ready`=0 after the load completes).

## Timing
- Reset values:
  - State = IDLE.
  - `cpu_en`=0, `busy`=0, `error`=0, `err_code`=0, `rx_ready`=0.
  - `spm_as_`=1, `spm_rw`=`READ`, `spm_addr`=0, `spm_wr_data`=0.
  - All counters and sums are 0.
- Reset asserted mid-operation aborts immediately and asynchronously. Any SPM strobe deasserts without waiting for the clock.
- `cpu_en`, `busy`, `error` and `err_code` are registered. SPM and `rx_ready` outputs decode combinationally from registered state only, never from inputs.
- `rx_ready` does not depend on `rx_valid`.
- A word write occurs the cycle after its 4th byte is accepted.
- With gap-free input, total load time from `start` to `cpu_en` is 1 + 4 + 5N + 2N cycles.
- `rx_valid` gaps stall the loader in HDR/DATA indefinitely; there is no timeout.

## Test plan
- N=2, words 0x00000013 and 0x00100093 streamed back-to-back → SPM writes to addresses 0 and 1 with those values, two reads follow, and `cpu_en`=1 at cycle 1+4+14.
- Header N=0 → no SPM access, RUN entered after the 4th header byte, `cpu_en`=1, `busy`=0.
- Header N=4097 (with `MAX_WORDS`=4096) → `error`=1, `err_code`=1, `rx_ready`=0, `spm_as_` never low.
- N=3, with the SPM model corrupting the readback of word 1 (bit 0 flipped) → `err_code`=2, `cpu_en`=0. A following `start` clears `error` and the reload succeeds.
- Random `rx_valid` gaps of 0–5 cycles, then reset pulsed low mid-DATA → outputs return to reset values asynchronously and no further SPM write occurs.
- `start` pulsed during DATA is ignored and the load completes. `start` in RUN drops `cpu_en` on the next edge and enters HDR.

Source files
------------

// File: rtl/spm_loader.sv
// spm_loader: boot-time program loader sitting in front of the CPU test SPM port.
//   Receives a byte stream (valid/ready), first a 4-byte little-endian word count N,
//   then N little-endian 32-bit words. Each word is written to SPM at BASE_ADDR+idx.
//   The image is then read back and summed; cpu_en rises only if the readback sum
//   matches the sum of the written words.
// Ports:
//   clk, reset (async, active low), start (one-cycle load request)
//   rx_data/rx_valid/rx_ready   : byte stream handshake
//   spm_addr/spm_as_/spm_rw/spm_wr_data/spm_rd_data : SPM test port
//   cpu_en, busy, error, err_code (0 none, 1 size too large, 2 checksum mismatch)
module spm_loader #(
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        cpu_en,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic SPM_READ  = 1'b1;
  localparam logic SPM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_VREQ, S_VCHK, S_RUN, S_ERR
  } state_t;

  state_t      r_state;
  logic [1:0]  r_bcnt;
  logic [31:0] r_nwords;
  logic [31:0] r_word;
  logic [29:0] r_idx;
  logic [31:0] r_sum;
  logic [31:0] r_vsum;
  logic        r_cpu_en;
  logic        r_busy;
  logic        r_error;
  logic [1:0]  r_err_code;

  logic [31:0] w_hdr_next;
  logic [31:0] w_word_next;
  logic [29:0] w_idx_inc;
  logic        w_last;
  logic [31:0] w_vsum_next;

  // Bytes arrive LSB first: shifting in from the top leaves byte k at [8k+7:8k].
  assign w_hdr_next  = {rx_data, r_nwords[31:8]};
  assign w_word_next = {rx_data, r_word[31:8]};
  assign w_idx_inc   = r_idx + 30'd1;
  assign w_last      = ({2'b00, w_idx_inc} == r_nwords);
  assign w_vsum_next = r_vsum + spm_rd_data;

  // Port outputs decode from registered state only, so an async reset
  // releases the SPM strobe immediately.
  always_comb begin
    rx_ready    = (r_state == S_HDR) || (r_state == S_DATA);
    spm_as_     = 1'b1;
    spm_rw      = SPM_READ;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (r_state == S_WRITE) begin
      spm_as_     = 1'b0;
      spm_rw      = SPM_WRITE;
      spm_addr    = BASE_ADDR + r_idx;
      spm_wr_data = r_word;
    end else if (r_state == S_VREQ) begin
      spm_as_  = 1'b0;
      spm_addr = BASE_ADDR + r_idx;
    end
  end

  assign cpu_en   = r_cpu_en;
  assign busy     = r_busy;
  assign error    = r_error;
  assign err_code = r_err_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_nwords   <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_vsum     <= '0;
      r_cpu_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            r_state    <= S_HDR;
            r_cpu_en   <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= '0;
            r_bcnt     <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_vsum     <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            r_nwords <= w_hdr_next;
            r_bcnt   <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              if (w_hdr_next == 32'd0) begin
                r_state  <= S_RUN;
                r_cpu_en <= 1'b1;
                r_busy   <= 1'b0;
              end else if (w_hdr_next > 32'(MAX_WORDS)) begin
                r_state    <= S_ERR;
                r_error    <= 1'b1;
                r_err_code <= 2'd1;
                r_busy     <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_word <= w_word_next;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_sum <= r_sum + r_word;
          if (w_last) begin
            r_idx   <= '0;
            r_state <= S_VREQ;
          end else begin
            r_idx   <= w_idx_inc;
            r_state <= S_DATA;
          end
        end
        S_VREQ: r_state <= S_VCHK;
        S_VCHK: begin
          r_vsum <= w_vsum_next;
          r_idx  <= w_idx_inc;
          if (w_last) begin
            r_busy <= 1'b0;
            if (w_vsum_next == r_sum) begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_error    <= 1'b1;
              r_err_code <= 2'd2;
            end
          end else begin
            r_state <= S_VREQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_loader.sv
module tb_spm_loader;

  localparam logic SPM_READ  = 1'b1;
  localparam logic SPM_WRITE = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [29:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data = '0;
  logic        cpu_en;
  logic        busy;
  logic        error;
  logic [1:0]  err_code;

  spm_loader #(.BASE_ADDR(30'h0), .MAX_WORDS(4096)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .cpu_en(cpu_en), .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // SPM model: samples the port mid-cycle; read data appears for the following cycle.
  logic [31:0] mem [16];
  int          n_wr = 0;
  int          n_rd = 0;
  int          n_strobe = 0;
  logic        corrupt = 1'b0;

  always @(negedge clk) begin
    if (!spm_as_) n_strobe++;
    if (!spm_as_ && spm_rw == SPM_WRITE) begin
      mem[spm_addr[3:0]] = spm_wr_data;
      n_wr++;
    end
    if (!spm_as_ && spm_rw == SPM_READ) begin
      spm_rd_data = mem[spm_addr[3:0]] ^ {31'b0, (corrupt && spm_addr == 30'd1)};
      n_rd++;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    bit r;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 50; k++) begin
      r = rx_ready;
      @(posedge clk); #1; cyc++;
      if (r) begin acc = 1; break; end
    end
    rx_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL byte_accept: got not-accepted expected accepted");
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1; cyc++; k++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL busy_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic do_load(input logic [31:0] n, input logic [127:0] words,
                         input int maxgap, input int nsend);
    pulse_start();
    for (int i = 0; i < 4; i++) feed_byte(n[8*i +: 8], $urandom_range(0, maxgap));
    for (int w = 0; w < nsend; w++)
      for (int b = 0; b < 4; b++)
        feed_byte(words[32*w + 8*b +: 8], $urandom_range(0, maxgap));
    wait_idle();
  endtask

  typedef struct {
    logic [31:0]  n;
    logic [127:0] words;     // word i in bits [32i+31:32i]
    logic         corrupt;
    int           maxgap;
    logic         exp_en;
    logic         exp_err;
    logic [1:0]   exp_code;
    int           exp_cyc;   // 0 = not checked (gapped stream)
    int           exp_acc;   // expected SPM writes (and reads)
  } vec_t;

  vec_t vecs [7];

  initial begin
    int wr0, rd0, st0, nsend;
    vecs[0] = '{32'd2, {64'h0, 32'h0010_0093, 32'h0000_0013}, 1'b0, 0, 1'b1, 1'b0, 2'd0, 19, 2};
    vecs[1] = '{32'd0, 128'h0, 1'b0, 0, 1'b1, 1'b0, 2'd0, 5, 0};
    vecs[2] = '{32'd4097, 128'h0, 1'b0, 0, 1'b0, 1'b1, 2'd1, 5, 0};
    vecs[3] = '{32'd3, {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b1, 0, 1'b0, 1'b1, 2'd2, 26, 3};
    vecs[4] = '{32'd3, {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 0, 1'b1, 1'b0, 2'd0, 26, 3};
    vecs[5] = '{32'd1, {96'h0, 32'hFFFF_FFFF}, 1'b0, 0, 1'b1, 1'b0, 2'd0, 12, 1};
    vecs[6] = '{32'd2, {64'h0, 32'h0000_0002, 32'hFFFF_FFFF}, 1'b0, 5, 1'b1, 1'b0, 2'd0, 0, 2};

    // Reset state
    #12;
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_err_code", {30'b0, err_code}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst_spm_as_", {31'b0, spm_as_}, 32'd1);
    chk("rst_spm_rw", {31'b0, spm_rw}, {31'b0, SPM_READ});
    chk("rst_spm_addr", {2'b0, spm_addr}, 32'd0);
    chk("rst_spm_wr_data", spm_wr_data, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      corrupt = vecs[v].corrupt;
      wr0 = n_wr; rd0 = n_rd; st0 = n_strobe;
      nsend = (vecs[v].n <= 32'd4) ? int'(vecs[v].n) : 0;
      do_load(vecs[v].n, vecs[v].words, vecs[v].maxgap, nsend);
      chk($sformatf("v%0d_cpu_en", v), {31'b0, cpu_en}, {31'b0, vecs[v].exp_en});
      chk($sformatf("v%0d_error", v), {31'b0, error}, {31'b0, vecs[v].exp_err});
      chk($sformatf("v%0d_err_code", v), {30'b0, err_code}, {30'b0, vecs[v].exp_code});
      chk($sformatf("v%0d_rx_ready", v), {31'b0, rx_ready}, 32'd0);
      chk($sformatf("v%0d_spm_as_", v), {31'b0, spm_as_}, 32'd1);
      chk($sformatf("v%0d_writes", v), n_wr - wr0, vecs[v].exp_acc);
      chk($sformatf("v%0d_reads", v), n_rd - rd0, vecs[v].exp_acc);
      chk($sformatf("v%0d_strobes", v), n_strobe - st0, 2 * vecs[v].exp_acc);
      if (vecs[v].exp_cyc != 0)
        chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      for (int i = 0; i < nsend; i++)
        chk($sformatf("v%0d_mem%0d", v, i), mem[i], vecs[v].words[32*i +: 32]);
    end
    corrupt = 1'b0;

    // start in RUN: cpu_en drops on the next edge and HDR is entered
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("run_start_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("run_start_busy", {31'b0, busy}, 32'd1);
    chk("run_start_rx_ready", {31'b0, rx_ready}, 32'd1);
    // start during DATA is ignored
    for (int i = 0; i < 4; i++) feed_byte((i == 0) ? 8'd1 : 8'd0, 0);
    feed_byte(8'h78, 0);
    feed_byte(8'h56, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("data_start_busy", {31'b0, busy}, 32'd1);
    chk("data_start_rx_ready", {31'b0, rx_ready}, 32'd1);
    feed_byte(8'h34, 0);
    feed_byte(8'h12, 0);
    wait_idle();
    chk("data_start_cpu_en", {31'b0, cpu_en}, 32'd1);
    chk("data_start_mem0", mem[0], 32'h1234_5678);

    // Reset while the SPM write strobe is active
    pulse_start();
    for (int i = 0; i < 4; i++) feed_byte((i == 0) ? 8'd3 : 8'd0, 0);
    feed_byte(8'hDD, 0); feed_byte(8'hCC, 0); feed_byte(8'hBB, 0); feed_byte(8'hAA, 0);
    chk("wr_spm_as_", {31'b0, spm_as_}, 32'd0);
    chk("wr_spm_rw", {31'b0, spm_rw}, {31'b0, SPM_WRITE});
    chk("wr_spm_wr_data", spm_wr_data, 32'hAABB_CCDD);
    wr0 = n_wr;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_spm_as_", {31'b0, spm_as_}, 32'd1);
    chk("async_rst_wr_data", spm_wr_data, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    chk("async_rst_no_write", n_wr - wr0, 32'd0);

    // Gapped stream, reset mid-DATA
    pulse_start();
    for (int i = 0; i < 4; i++) feed_byte((i == 0) ? 8'd2 : 8'd0, $urandom_range(0, 5));
    feed_byte(8'h11, $urandom_range(0, 5));
    feed_byte(8'h22, $urandom_range(0, 5));
    wr0 = n_wr; st0 = n_strobe;
    #2 reset = 1'b0;
    #1;
    chk("mid_data_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_data_rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("mid_data_rst_addr", {2'b0, spm_addr}, 32'd0);
    rx_valid = 1'b1; rx_data = 8'h33;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("mid_data_rst_no_write", n_wr - wr0, 32'd0);
    chk("mid_data_rst_no_strobe", n_strobe - st0, 32'd0);
    chk("mid_data_rst_idle_ready", {31'b0, rx_ready}, 32'd0);
    chk("mid_data_rst_cpu_en", {31'b0, cpu_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
